// File: rtl/bus_arbiter_if.sv
// Bundle of the arbiter's request, grant and status signals for the shared system bus.
// Latency: none, wires only.
// Backpressure: requests are held as levels until the matching grant is observed.
interface bus_arbiter_if #(
  parameter int NCH = 4
);
  logic           breq_;
  logic           bgrt_;
  logic [NCH-1:0] chreq_;
  logic [NCH-1:0] chburst;
  logic           eop_;
  logic [NCH-1:0] chgrt_;
  logic           busy;
  logic [2:0]     owner;

  // Requester side: the processor, the DMA channels and the DMA engine.
  modport master (
    output breq_, chreq_, chburst, eop_,
    input  bgrt_, chgrt_, busy, owner
  );

  // Arbiter side.
  modport slave (
    input  breq_, chreq_, chburst, eop_,
    output bgrt_, chgrt_, busy, owner
  );
endinterface

// File: rtl/bus_arbiter.sv
// Hands the shared bus to the processor or one DMA channel (round-robin), with a one-cycle dead slot per hand-over.
// Latency: a request sampled at edge n is granted after edge n; a release sampled at edge n frees the bus after edge n.
// Backpressure: requesters hold their level until granted; single-mode channels are cut after MAX_TENURE cycles if others wait.
module bus_arbiter #(
  parameter int NCH        = 4,
  parameter int MAX_TENURE = 16,
  parameter int CPU_PRI    = 1
) (
  input logic          clk,
  input logic          reset_,
  bus_arbiter_if.slave bus
);
  localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;
  typedef logic [IW-1:0] idx_t;
  typedef enum logic [1:0] {IDLE, CPU, DMA, TURN} state_t;
  localparam logic [7:0] TEN_LAST = 8'(MAX_TENURE - 1);

  state_t     state, state_nxt;
  idx_t       idx, rr_ptr, ch_win;
  logic [7:0] tenure;
  logic       burst;
  logic       ch_found, burst_win, take_ch;
  logic       cpu_req, own_req, others;

  assign cpu_req = !bus.breq_;

  // Round-robin pick: channels above rr_ptr first, then wrap around to 0..rr_ptr.
  always_comb begin
    ch_found  = 1'b0;
    ch_win    = '0;
    burst_win = 1'b0;
    for (int j = 0; j < NCH; j++) begin
      if (!ch_found && !bus.chreq_[j] && idx_t'(j) > rr_ptr) begin
        ch_found = 1'b1;
        ch_win   = idx_t'(j);
      end
    end
    for (int j = 0; j < NCH; j++) begin
      if (!ch_found && !bus.chreq_[j] && idx_t'(j) <= rr_ptr) begin
        ch_found = 1'b1;
        ch_win   = idx_t'(j);
      end
    end
    for (int j = 0; j < NCH; j++) begin
      if (idx_t'(j) == ch_win) burst_win = bus.chburst[j];
    end
  end

  // Owner's own request level, and whether anybody else is waiting for the bus.
  always_comb begin
    own_req = 1'b0;
    others  = cpu_req;
    for (int j = 0; j < NCH; j++) begin
      if (idx_t'(j) == idx) own_req = !bus.chreq_[j];
      else if (!bus.chreq_[j]) others = 1'b1;
    end
  end

  // Next-state: IDLE and TURN both arbitrate; owners release into the TURN dead slot.
  always_comb begin
    state_nxt = state;
    take_ch   = 1'b0;
    case (state)
      IDLE, TURN: begin
        state_nxt = IDLE;
        if (cpu_req && (CPU_PRI != 0 || !ch_found)) begin
          state_nxt = CPU;
        end else if (ch_found) begin
          state_nxt = DMA;
          take_ch   = 1'b1;
        end
      end
      CPU: if (!cpu_req) state_nxt = TURN;
      DMA: begin
        if (!own_req || !bus.eop_ || (!burst && tenure == TEN_LAST && others))
          state_nxt = TURN;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, granted index, round-robin pointer, latched mode and saturating tenure counter.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state  <= IDLE;
      idx    <= '0;
      rr_ptr <= idx_t'(NCH - 1);
      tenure <= '0;
      burst  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (take_ch) begin
        idx    <= ch_win;
        rr_ptr <= ch_win;
        burst  <= burst_win;
        tenure <= '0;
      end else if (state == DMA && tenure != TEN_LAST) begin
        tenure <= tenure + 8'd1;
      end
    end
  end

  // Outputs decode straight from the state and index flops, so reset drops them immediately.
  always_comb begin
    bus.bgrt_ = (state != CPU);
    bus.busy  = (state == CPU) || (state == DMA);
    bus.owner = 3'd0;
    for (int j = 0; j < NCH; j++) begin
      bus.chgrt_[j] = !(state == DMA && idx == idx_t'(j));
    end
    if (state == CPU) bus.owner = 3'd1;
    else if (state == DMA) bus.owner = 3'd2 + 3'(idx);
  end
endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: a behavioural owner model checked every cycle, plus literal spot checks.
// Inputs change 1 time unit after the rising edge; outputs are compared on the falling edge.
// Every wait is a bounded loop, so the run always reaches the summary line.
module tb_bus_arbiter;
  localparam int NCH        = 4;
  localparam int MAX_TENURE = 16;
  localparam int CPU_PRI    = 1;

  logic clk    = 1'b0;
  logic reset_ = 1'b0;
  int   vectors = 0;
  int   errors  = 0;

  bus_arbiter_if #(.NCH(NCH)) bus ();

  bus_arbiter #(.NCH(NCH), .MAX_TENURE(MAX_TENURE), .CPU_PRI(CPU_PRI)) dut (
    .clk(clk),
    .reset_(reset_),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Model: owner is 0 (nobody), 1 (processor) or 2+i (channel i).
  int m_owner = 0;
  int m_cnt   = 0;
  int m_rr    = NCH - 1;
  bit m_burst = 1'b0;

  always @(posedge clk or negedge reset_) begin : model
    int win;
    int ch;
    bit oth;
    if (!reset_) begin
      m_owner = 0;
      m_cnt   = 0;
      m_rr    = NCH - 1;
      m_burst = 1'b0;
    end else if (m_owner == 0) begin
      win = -1;
      for (int k = 1; k <= NCH; k++) begin
        int c;
        c = (m_rr + k) % NCH;
        if (win < 0 && bus.chreq_[c] == 1'b0) win = c;
      end
      if (bus.breq_ == 1'b0 && (CPU_PRI != 0 || win < 0)) begin
        m_owner = 1;
      end else if (win >= 0) begin
        m_owner = 2 + win;
        m_rr    = win;
        m_burst = bus.chburst[win];
        m_cnt   = 0;
      end
    end else if (m_owner == 1) begin
      if (bus.breq_ == 1'b1) m_owner = 0;
    end else begin
      ch  = m_owner - 2;
      oth = (bus.breq_ == 1'b0);
      for (int j = 0; j < NCH; j++) if (j != ch && bus.chreq_[j] == 1'b0) oth = 1'b1;
      if (bus.chreq_[ch] == 1'b1 || bus.eop_ == 1'b0 ||
          (!m_burst && m_cnt == MAX_TENURE - 1 && oth))
        m_owner = 0;
      else if (m_cnt < MAX_TENURE - 1)
        m_cnt++;
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin : compare
    logic [NCH-1:0] exp_ch;
    for (int j = 0; j < NCH; j++) exp_ch[j] = (m_owner != 2 + j);
    vectors++;
    if (bus.bgrt_ !== (m_owner != 1) || bus.chgrt_ !== exp_ch ||
        bus.busy !== (m_owner != 0) || bus.owner !== 3'(m_owner)) begin
      errors++;
      $display("FAIL cycle_compare t=%0t: dut bgrt_=%b chgrt_=%b busy=%b owner=%0d, model bgrt_=%b chgrt_=%b busy=%b owner=%0d",
               $time, bus.bgrt_, bus.chgrt_, bus.busy, bus.owner,
               (m_owner != 1), exp_ch, (m_owner != 0), m_owner);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int g;
    bus.breq_   = 1'b1;
    bus.chreq_  = '1;
    bus.chburst = '0;
    bus.eop_    = 1'b1;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("reset_bgrt", bus.bgrt_, 1);
    chk("reset_chgrt", bus.chgrt_, 15);
    chk("reset_busy", bus.busy, 0);
    chk("reset_owner", bus.owner, 0);
    #3 reset_ = 1'b1;

    // Processor tenure; eop_ during it is ignored.
    bus.breq_ = 1'b0;
    tick();
    chk("cpu_bgrt", bus.bgrt_, 0);
    chk("cpu_owner", bus.owner, 1);
    chk("cpu_busy", bus.busy, 1);
    tick();
    bus.eop_ = 1'b0;
    tick();
    bus.eop_ = 1'b1;
    tick();
    chk("cpu_eop_ignored", bus.owner, 1);
    bus.breq_ = 1'b1;
    tick();
    chk("cpu_release_bgrt", bus.bgrt_, 1);
    chk("cpu_turn_owner", bus.owner, 0);
    tick();
    chk("cpu_idle_owner", bus.owner, 0);

    // All channels request; each holds 3 cycles; order ch0..ch3 with one dead cycle each.
    bus.chreq_ = '0;
    for (int e = 0; e < NCH; e++) begin
      tick();
      chk("rr_grant_owner", bus.owner, 2 + e);
      tick();
      tick();
      bus.chreq_[e] = 1'b1;
      tick();
      chk("rr_turn_owner", bus.owner, 0);
    end
    tick();
    chk("rr_idle_owner", bus.owner, 0);

    // Processor beats ch2, then ch2 after one dead cycle.
    bus.breq_  = 1'b0;
    bus.chreq_ = 4'b1011;
    tick();
    chk("pri_cpu_first", bus.owner, 1);
    tick();
    tick();
    bus.breq_ = 1'b1;
    tick();
    chk("pri_turn", bus.owner, 0);
    tick();
    chk("pri_ch2_chgrt", bus.chgrt_, 11);
    chk("pri_ch2_owner", bus.owner, 4);
    bus.chreq_ = '1;
    tick();
    tick();

    // Single-mode ch1 forced off after MAX_TENURE cycles by a waiting processor.
    bus.chreq_  = 4'b1101;
    bus.chburst = 4'b0000;
    tick();
    chk("tenure_ch1_grant", bus.owner, 3);
    g = 1;
    tick();
    g++;
    tick();
    g++;
    bus.breq_ = 1'b0;
    for (int n = 0; n < 40 && bus.owner == 3'd3; n++) begin
      tick();
      if (bus.owner == 3'd3) g++;
    end
    chk("tenure_length", g, MAX_TENURE);
    chk("tenure_turn", bus.owner, 0);
    tick();
    chk("tenure_cpu_bgrt", bus.bgrt_, 0);
    tick();
    bus.breq_ = 1'b1;
    tick();
    chk("tenure_cpu_release", bus.owner, 0);
    tick();
    chk("tenure_ch1_regrant", bus.owner, 3);
    bus.chreq_ = '1;
    tick();
    tick();

    // Burst ch0 is not preempted; eop_ together with withdrawal gives one release.
    bus.chreq_  = 4'b1110;
    bus.chburst = 4'b0001;
    tick();
    chk("burst_grant", bus.owner, 2);
    bus.breq_ = 1'b0;
    g = 1;
    for (int n = 0; n < 39; n++) begin
      tick();
      if (bus.owner == 3'd2) g++;
    end
    chk("burst_no_preempt", g, 40);
    bus.eop_      = 1'b0;
    bus.chreq_[0] = 1'b1;
    tick();
    bus.eop_ = 1'b1;
    chk("burst_eop_turn", bus.owner, 0);
    tick();
    chk("burst_then_cpu", bus.bgrt_, 0);
    bus.breq_   = 1'b1;
    bus.chburst = '0;
    tick();
    tick();

    // Asynchronous reset in the middle of a ch3 tenure.
    bus.chreq_ = 4'b0111;
    tick();
    chk("rst_ch3_grant", bus.owner, 5);
    tick();
    #2 reset_ = 1'b0;
    #1;
    chk("rst_async_chgrt", bus.chgrt_, 15);
    chk("rst_async_busy", bus.busy, 0);
    chk("rst_async_owner", bus.owner, 0);
    bus.chreq_ = 4'b1001;  // channels 1 and 2 requesting
    @(posedge clk);
    #3 reset_ = 1'b1;
    tick();
    chk("rst_ch1_first", bus.owner, 3);
    bus.chreq_ = 4'b1011;
    tick();
    tick();
    chk("rst_ch2_next", bus.owner, 4);
    bus.chreq_ = '1;
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
